// File: rtl/peripheral_bus_pkg.sv
// Shared types and constants for the peripheral bus initiator.
// The request check lives here so every user agrees on what is rejected.
package peripheral_bus_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_RESP} state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam int PERIPH_WINDOW_BIT = 31;

   // Peripherals only take full-word writes, so sub-word stores are rejected too.
   function automatic logic req_error(input logic i_write, input logic [31:0] i_addr,
                                      input logic [1:0] i_size);
      logic w_err;
      w_err = !i_addr[PERIPH_WINDOW_BIT]
            || (i_size == 2'd3)
            || ((i_size == SIZE_HALF) && i_addr[0])
            || ((i_size == SIZE_WORD) && (i_addr[1:0] != 2'b00))
            || (i_write && (i_size != SIZE_WORD));
      return w_err;
   endfunction

endpackage

// File: rtl/peripheral_bus_master_if.sv
// CPU request/response and peripheral strobe signals of the bus initiator.
interface peripheral_bus_master_if;

   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [31:0] reqAddress;
   logic [31:0] reqWriteData;
   logic [1:0]  reqSize;
   logic        reqUnsigned;
   logic        respValid;
   logic [31:0] respReadData;
   logic        respError;
   logic        periphReadEnable;
   logic        periphWriteEnable;
   logic [30:0] periphAddress;
   logic [31:0] periphDataOut;
   logic [31:0] periphDataIn;

   modport master (
      input  reqValid, reqWrite, reqAddress, reqWriteData, reqSize, reqUnsigned, periphDataIn,
      output reqReady, respValid, respReadData, respError,
             periphReadEnable, periphWriteEnable, periphAddress, periphDataOut
   );

   modport slave (
      output reqValid, reqWrite, reqAddress, reqWriteData, reqSize, reqUnsigned, periphDataIn,
      input  reqReady, respValid, respReadData, respError,
             periphReadEnable, periphWriteEnable, periphAddress, periphDataOut
   );

endinterface

// File: rtl/peripheral_bus_master_load_extender.sv
// Picks the addressed byte/half out of a read word and sign/zero-extends it.
module load_extender
   import peripheral_bus_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [1:0]  i_addr,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_data[8*i_addr +: 8];
      w_half = i_data[16*i_addr[1] +: 16];
      o_data = i_data;
      case (i_size)
         SIZE_BYTE: o_data = {{24{w_byte[7]  & ~i_unsigned}}, w_byte};
         SIZE_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
         default:   o_data = i_data;
      endcase
   end

endmodule

// File: rtl/peripheral_bus_master.sv
// Peripheral bus initiator: one CPU load/store at a time, fixed read latency,
// one response pulse per accepted request.
module peripheral_bus_master
   import peripheral_bus_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   peripheral_bus_master_if.master bus
);

   localparam logic [3:0] LAT = 4'(READ_LATENCY);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [1:0]  r_addr_lo;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_we;
   logic        r_re;
   logic [30:0] r_paddr;
   logic [31:0] r_dout;
   logic        r_resp_valid;
   logic        r_resp_err;
   logic [31:0] r_rdata;
   logic [31:0] w_ext;

   load_extender u_ext (
      .i_data     (bus.periphDataIn),
      .i_addr     (r_addr_lo),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_data     (w_ext)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_addr_lo    <= '0;
         r_size       <= '0;
         r_unsigned   <= 1'b0;
         r_we         <= 1'b0;
         r_re         <= 1'b0;
         r_paddr      <= '0;
         r_dout       <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_rdata      <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_rdata      <= '0;
         r_we         <= 1'b0;
         r_dout       <= '0;
         case (r_state)
            ST_IDLE: if (bus.reqValid) begin
               r_addr_lo  <= bus.reqAddress[1:0];
               r_size     <= bus.reqSize;
               r_unsigned <= bus.reqUnsigned;
               if (req_error(bus.reqWrite, bus.reqAddress, bus.reqSize)) begin
                  r_state      <= ST_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b1;
               end else begin
                  r_paddr <= {bus.reqAddress[30:2], 2'b00};
                  if (bus.reqWrite) begin
                     r_state <= ST_WRITE;
                     r_we    <= 1'b1;
                     r_dout  <= bus.reqWriteData;
                  end else begin
                     r_state <= ST_READ;
                     r_re    <= 1'b1;
                     r_cnt   <= '0;
                  end
               end
            end
            ST_WRITE: begin
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
            end
            ST_READ: begin
               r_cnt <= r_cnt + 4'd1;
               // Counter reaching the latency marks the edge where read data is valid.
               if (r_cnt == LAT) begin
                  r_state      <= ST_RESP;
                  r_re         <= 1'b0;
                  r_rdata      <= w_ext;
                  r_resp_valid <= 1'b1;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.reqReady          = (r_state == ST_IDLE);
   assign bus.respValid         = r_resp_valid;
   assign bus.respError         = r_resp_err;
   assign bus.respReadData      = r_rdata;
   assign bus.periphReadEnable  = r_re;
   assign bus.periphWriteEnable = r_we;
   assign bus.periphAddress     = r_paddr;
   assign bus.periphDataOut     = r_dout;

endmodule

// File: tb/tb_peripheral_bus_master.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and checks.
module tb_peripheral_bus_master;

   localparam int LAT = 1;

   typedef struct {
      string       name;
      logic        err;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   peripheral_bus_master_if bus();

   peripheral_bus_master #(.READ_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   int          cyc = 0;
   int          ntests = 0;
   int          nfail = 0;
   exp_t        q[$];
   int          acc_cyc[$];
   int          we_cnt = 0;
   int          re_cnt = 0;
   logic [30:0] we_addr = '0;
   logic [31:0] we_data = '0;
   logic [30:0] re_addr = '0;
   logic [31:0] rd_value = '0;
   int          rcnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Responder: real data only once the strobe has been high for LAT edges.
   always @(negedge clk) begin
      rcnt = bus.periphReadEnable ? rcnt + 1 : 0;
      bus.periphDataIn = (bus.periphReadEnable && rcnt == LAT + 1) ? rd_value : 32'hDEAD_BEEF;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (bus.respValid) begin
            if (q.size() == 0) begin
               ntests++;
               nfail++;
               $display("FAIL unexpected_resp: got respValid=1 at cycle %0d, required 0", cyc);
            end else begin
               e = q.pop_front();
               chk({e.name, "_err"},  32'(bus.respError), 32'(e.err));
               chk({e.name, "_data"}, bus.respReadData, e.data);
               chk({e.name, "_cyc"},  32'(cyc), 32'(e.cyc));
            end
         end
         if (bus.periphWriteEnable) begin
            we_cnt++;
            we_addr = bus.periphAddress;
            we_data = bus.periphDataOut;
         end
         if (bus.periphReadEnable) begin
            re_cnt++;
            re_addr = bus.periphAddress;
         end
         if (bus.reqValid && bus.reqReady) acc_cyc.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input string nm, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic eerr, input logic [31:0] edata, input int delay,
                        input bit push);
      exp_t e;
      int   guard = 0;
      we_cnt = 0;
      re_cnt = 0;
      bus.reqValid     = 1'b1;
      bus.reqWrite     = wr;
      bus.reqAddress   = addr;
      bus.reqWriteData = wdata;
      bus.reqSize      = size;
      bus.reqUnsigned  = uns;
      while (!bus.reqReady && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) begin
         ntests++;
         nfail++;
         $display("FAIL %s_accept: got reqReady=0 for 50 cycles, required 1", nm);
      end
      if (push) begin
         e.name = nm; e.err = eerr; e.data = edata; e.cyc = cyc + delay;
         q.push_back(e);
      end
      step();
      bus.reqValid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int guard = 0;
      while (q.size() != 0 && guard < 50) begin
         step();
         guard++;
      end
      if (q.size() != 0) begin
         ntests++;
         nfail++;
         $display("FAIL %s_drain: got %0d responses pending, required 0", nm, q.size());
         q.delete();
      end
      repeat (2) step();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish by 200us, required finish");
      $fatal(1);
   end

   initial begin
      int c0;
      bus.reqValid = 0; bus.reqWrite = 0; bus.reqAddress = '0; bus.reqWriteData = '0;
      bus.reqSize = '0; bus.reqUnsigned = 0;
      repeat (3) step();
      chk("rst_ready",  32'(bus.reqReady), 32'd1);
      chk("rst_rvalid", 32'(bus.respValid), 32'd0);
      chk("rst_rerr",   32'(bus.respError), 32'd0);
      chk("rst_rdata",  bus.respReadData, 32'd0);
      chk("rst_strobe", {30'd0, bus.periphReadEnable, bus.periphWriteEnable}, 32'd0);
      chk("rst_paddr",  32'(bus.periphAddress), 32'd0);
      chk("rst_dout",   bus.periphDataOut, 32'd0);
      reset = 0;
      step();

      issue("st_word", 1, 32'h8000_0000, 32'h0000_002A, 2'd2, 0, 0, 32'd0, 2, 1);
      drain("st_word");
      chk("st_we_cnt", 32'(we_cnt), 32'd1);
      chk("st_re_cnt", 32'(re_cnt), 32'd0);
      chk("st_paddr",  32'(we_addr), 32'h0000_0000);
      chk("st_dout",   we_data, 32'h0000_002A);

      rd_value = 32'h0000_0001;
      issue("ld_word", 0, 32'h9000_0000, 32'd0, 2'd2, 0, 0, 32'h0000_0001, 2 + LAT, 1);
      drain("ld_word");
      chk("ld_re_cnt", 32'(re_cnt), 32'(LAT + 1));
      chk("ld_we_cnt", 32'(we_cnt), 32'd0);
      chk("ld_paddr",  32'(re_addr), 32'h1000_0000);

      rd_value = 32'h80FF_1234;
      issue("ld_byte_s", 0, 32'hA000_0003, 32'd0, 2'd0, 0, 0, 32'hFFFF_FF80, 2 + LAT, 1);
      drain("ld_byte_s");
      chk("ldb_paddr", 32'(re_addr), 32'h2000_0000);
      issue("ld_byte_u", 0, 32'hA000_0003, 32'd0, 2'd0, 1, 0, 32'h0000_0080, 2 + LAT, 1);
      drain("ld_byte_u");
      issue("ld_half_s", 0, 32'h8000_0002, 32'd0, 2'd1, 0, 0, 32'hFFFF_80FF, 2 + LAT, 1);
      drain("ld_half_s");
      issue("ld_byte1_u", 0, 32'h8000_0001, 32'd0, 2'd0, 1, 0, 32'h0000_0012, 2 + LAT, 1);
      drain("ld_byte1_u");

      issue("err_half", 0, 32'h8000_0001, 32'd0, 2'd1, 0, 1, 32'd0, 1, 1);
      drain("err_half");
      chk("err_half_strobes", 32'(we_cnt + re_cnt), 32'd0);
      issue("err_stbyte", 1, 32'h8000_0000, 32'h55, 2'd0, 0, 1, 32'd0, 1, 1);
      drain("err_stbyte");
      chk("err_stbyte_strobes", 32'(we_cnt + re_cnt), 32'd0);
      issue("err_window", 0, 32'h0000_0010, 32'd0, 2'd2, 0, 1, 32'd0, 1, 1);
      drain("err_window");
      chk("err_window_strobes", 32'(we_cnt + re_cnt), 32'd0);
      issue("err_size3", 0, 32'h8000_0000, 32'd0, 2'd3, 0, 1, 32'd0, 1, 1);
      drain("err_size3");
      issue("err_wmis", 0, 32'h8000_0002, 32'd0, 2'd2, 0, 1, 32'd0, 1, 1);
      drain("err_wmis");

      // Abort a load in its first strobe cycle.
      issue("rst_mid", 0, 32'h8000_0004, 32'd0, 2'd2, 0, 0, 32'd0, 0, 0);
      chk("rstmid_re_before", 32'(bus.periphReadEnable), 32'd1);
      reset = 1;
      step();
      chk("rstmid_re_after", 32'(bus.periphReadEnable), 32'd0);
      chk("rstmid_ready",    32'(bus.reqReady), 32'd1);
      chk("rstmid_rvalid",   32'(bus.respValid), 32'd0);
      reset = 0;
      repeat (6) step();

      // Back-to-back stores with reqValid held: one accept every 3 cycles.
      acc_cyc.delete();
      c0 = cyc;
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         e.name = $sformatf("b2b%0d", k); e.err = 0; e.data = 0; e.cyc = c0 + 2 + 3 * k;
         q.push_back(e);
      end
      we_cnt = 0;
      bus.reqValid = 1; bus.reqWrite = 1; bus.reqAddress = 32'h8000_0010;
      bus.reqWriteData = 32'h1234_5678; bus.reqSize = 2'd2; bus.reqUnsigned = 0;
      repeat (7) step();
      bus.reqValid = 0;
      drain("b2b");
      chk("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
      for (int k = 0; k < 3 && k < acc_cyc.size(); k++)
         chk($sformatf("b2b_acc%0d_cyc", k), 32'(acc_cyc[k]), 32'(c0 + 3 * k));
      chk("b2b_we_cnt", 32'(we_cnt), 32'd3);
      chk("b2b_paddr",  32'(we_addr), 32'h0000_0010);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/peripheral_bus_master.md
# peripheral_bus_master

Initiator side of the memory-mapped peripheral bus. Accepts single load/store requests from the CPU memory stage for the peripheral window (address bit 31 = 1), drives the peripheral read/write strobes, address and write data, and returns one response per request. Performs alignment and size checks, waits a fixed read latency, and extracts and extends byte and half-word load data.

## Interface

**Parameters**
- `READ_LATENCY`, default 1: clock edges from the first `periphReadEnable` cycle until `periphDataIn` is valid. Legal range 1 to 15.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `reqValid`, in, 1: CPU request present.
- `reqReady`, out, 1: block can accept a request.
- `reqWrite`, in, 1: 1 = store, 0 = load.
- `reqAddress`, in, 32: byte address.
- `reqWriteData`, in, 32: store data.
- `reqSize`, in, 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `reqUnsigned`, in, 1: zero-extend loads when 1, sign-extend when 0.
- `respValid`, out, 1: one-cycle response pulse.
- `respReadData`, out, 32: extended load data.
- `respError`, out, 1: request rejected; no bus access made.
- `periphReadEnable`, out, 1: read strobe.
- `periphWriteEnable`, out, 1: write strobe.
- `periphAddress`, out, 31: `{addr[30:2], 2'b00}`.
- `periphDataOut`, out, 32: write data to peripherals.
- `periphDataIn`, in, 32: read data from peripherals.

## Operation

- **States:** IDLE, WRITE, READ, RESP.
- **IDLE.** `reqReady` = 1 only in this state. On `reqValid`, the block latches the address, data, size and unsigned flag, then validates:
  - an error is raised if `addr[31]` = 0, or `reqSize` = 3, or a half access has `addr[0]` = 1, or a word access has `addr[1:0]` != 0, or the request is a store with `reqSize` != word (peripherals are write-word-only);
  - on error, the next state is RESP with the error flag set;
  - otherwise a store goes to WRITE and a load goes to READ with the latency counter cleared.
- **WRITE.** `periphWriteEnable` = 1 and `periphDataOut` = latched data for exactly one cycle, then RESP.
- **READ.** `periphReadEnable` held at 1. The counter increments every cycle. When the counter equals `READ_LATENCY`, `periphDataIn` is sampled at that edge and the state moves to RESP.
- **Load extraction:**
  - byte: `data[8*addr[1:0] +: 8]`;
  - half: `data[16*addr[1] +: 16]`;
  - word: data unchanged;
  - sub-word results are sign- or zero-extended to 32 bits according to `reqUnsigned`.
- **RESP.** `respValid` = 1 for one cycle, then IDLE.
  - `respReadData` = 0 for stores and errors.
  - `respError` is meaningful only while `respValid` = 1.
- `periphAddress` is held stable from WRITE/READ entry until the next accept.
- Strobes are 0 in all states other than WRITE and READ.

## Timing

- The request is accepted at edge a; the cycle after it is a+1.
- **Store:** `periphWriteEnable` high in cycle a+1, `respValid` in cycle a+2, `reqReady` again in cycle a+3.
- **Load:** `periphReadEnable` high in cycles a+1 through a+1+`READ_LATENCY` inclusive, `respValid` in cycle a+2+`READ_LATENCY`.
- **Error:** `respValid` with `respError` = 1 in cycle a+1. No strobe is asserted.
- **No response backpressure.** `respValid` is a pulse and the CPU must capture it.
- **Reset:**
  - state returns to IDLE; `reqReady` = 1;
  - all other outputs are 0: strobes, `periphAddress`, `periphDataOut`, `respValid`, `respReadData`, `respError`.
- **Reset mid-operation:** strobes drop at the next edge and no response is issued for the aborted request.
- A `reqValid` in a non-IDLE cycle is ignored. The CPU holds the request until `reqReady`.

## Structure

- **Package `peripheral_bus_pkg`:** state enum; size constants `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`; constant `PERIPH_WINDOW_BIT` = 31.
- **Sub-module `load_extender`:** combinational block with inputs data, `addr[1:0]`, size and unsigned flag, and output the extended 32-bit value.

## Test plan

- Store word to 0x8000_0000 with data 0x0000_002A: `periphWriteEnable` for 1 cycle, `periphAddress` 0x000_0000, `periphDataOut` 0x2A, `respValid` 2 cycles after accept with `respError` = 0.
- Load word from 0x9000_0000 with `READ_LATENCY` = 1 and the responder returning 0x0000_0001 one cycle after the strobe: `respReadData` 0x1, `respValid` at a+3, `periphReadEnable` high for 2 cycles.
- Load byte from 0xA000_0003, with `periphDataIn` = 0x80FF_1234 and `reqUnsigned` = 0: response 0xFFFF_FF80. Repeat with `reqUnsigned` = 1: response 0x0000_0080.
- Error cases, each giving `respError` = 1 at a+1 with no strobe: load half at 0x8000_0001; store byte at 0x8000_0000; load word at 0x0000_0010.
- Assert `reset` during cycle a+1 of a load: no `respValid`, `periphReadEnable` = 0 after the next edge, `reqReady` = 1.
- Back-to-back stores with `reqValid` held high: accepts every 3 cycles, and no request is accepted while in WRITE or RESP.
